// File: rtl/rr_pkt_arbiter.sv
// rr_pkt_arbiter: round-robin packet arbiter with registered output stage and length guard
module rr_pkt_arbiter #(
  parameter int N_CH = 8,
  parameter int DATA_W = 32,
  parameter int MAX_BEATS = 64,
  parameter int CW = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CW-1:0]            out_ch,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     len_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int BW = $clog2(MAX_BEATS) + 1;
  logic [0:0] state;
  logic [CW-1:0] ptr, grant, sel;
  logic [BW-1:0] beat_cnt;
  logic [N_CH-1:0] req;
  logic found, acc, eff_last;
  assign req = in_valid & ch_en;
  assign busy = state == BUSY;
  assign in_ready = (busy && !reset && (!out_valid || out_ready)) ? {{(N_CH-1){1'b0}}, 1'b1} << grant : '0;
  assign acc = in_valid[grant] && in_ready[grant];
  assign eff_last = in_last[grant] || beat_cnt == BW'(MAX_BEATS - 1);
  always_comb begin
    sel = ptr;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req[(int'(ptr) + i) % N_CH]) begin
        sel = CW'((int'(ptr) + i) % N_CH);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      beat_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_ch <= '0;
      len_err <= 1'b0;
    end else begin
      if (state == IDLE && |req) begin
        grant <= sel;
        beat_cnt <= '0;
        state <= BUSY;
      end
      if (acc) begin
        out_data <= in_data[int'(grant)*DATA_W +: DATA_W];
        out_ch <= grant;
        out_last <= eff_last;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (acc && eff_last) begin
        state <= IDLE;
        ptr <= (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;
        len_err <= len_err || !in_last[grant];
      end
      out_valid <= acc || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// tb_rr_pkt_arbiter: directed stimulus with a queue-based scoreboard for rr_pkt_arbiter
module tb_rr_pkt_arbiter;
  localparam int N = 8;
  localparam int DW = 32;
  localparam int MB = 4;
  typedef struct packed {logic [31:0] d; logic l; logic [2:0] c;} beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] ch_en = 8'hFF;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_last = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0] in_ready;
  logic out_valid, out_last, busy, len_err;
  logic out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [2:0] out_ch;
  beat_t exp_q[$];
  beat_t e;
  int checks = 0;
  int passes = 0;
  int first_wait = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic prev_l = 1'b0;
  always #5 clk = ~clk;
  rr_pkt_arbiter #(.N_CH(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready), .busy(busy), .len_err(len_err)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic push(input logic [31:0] d, input logic l, input logic [2:0] c);
    exp_q.push_back('{d: d, l: l, c: c});
  endtask
  // Called #1 after a rising edge; each beat is held until the DUT accepts it.
  task automatic send(input int ch, input int n, input logic [31:0] base, input logic [7:0] lmask, input logic [7:0] emask);
    int t;
    for (int b = 0; b < n; b++) begin
      in_valid[ch] = 1'b1;
      in_data[ch*DW +: DW] = base + b;
      in_last[ch] = lmask[b];
      push(base + b, emask[b], 3'(ch));
      t = 0;
      @(negedge clk);
      while (!in_ready[ch] && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (b == 0) first_wait = t;
      check("beat_accept", {63'd0, in_ready[ch]}, 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid[ch] = 1'b0;
    in_last[ch] = 1'b0;
  endtask
  // All channels in vmask offer 1-beat packets (data 0x10+ch) for n edges.
  task automatic bulk(input logic [7:0] vmask, input logic [7:0] en, input int n);
    for (int c = 0; c < N; c++) in_data[c*DW +: DW] = 32'h10 + c;
    ch_en = en;
    in_valid = vmask;
    in_last = vmask;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("bubble_busy", {63'd0, busy}, {63'd0, k[0]});
      check("masked_ready", {56'd0, in_ready & ~en}, 64'd0);
      @(posedge clk);
    end
    #1;
    in_valid = '0;
    in_last = '0;
    ch_en = 8'hFF;
  endtask
  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_beat: got data %0h ch %0d with nothing expected", out_data, out_ch);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.d));
        check("out_last", {63'd0, out_last}, {63'd0, e.l});
        check("out_ch", 64'(out_ch), 64'(e.c));
      end
    end
    if (prev_stall) begin
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_data", 64'(out_data), 64'(prev_d));
      check("stall_last", {63'd0, out_last}, {63'd0, prev_l});
    end
    if (!reset && out_valid && !out_ready) check("stall_ready", {56'd0, in_ready}, 64'd0);
    prev_stall = !reset && out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_len_err", {63'd0, len_err}, 64'd0);
    check("rst_in_ready", {56'd0, in_ready}, 64'd0);
    // ch0 three-beat packet
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_data[31:0] = 32'hA0;
    @(negedge clk);
    check("idle_in_ready", {56'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    send(0, 3, 32'hA0, 8'b100, 8'b100);
    check("first_ready_wait", 64'(first_wait), 64'd0);
    @(negedge clk);
    check("busy_after_pkt", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    // ptr=1 after ch0 released: ch1 beats ch0
    push(32'h11, 1'b1, 3'd1);
    push(32'h10, 1'b1, 3'd0);
    bulk(8'h03, 8'hFF, 4);
    drain();
    // all channels, full enable, wrap 7->0
    do_reset();
    for (int c = 0; c < N; c++) push(32'h10 + c, 1'b1, 3'(c));
    push(32'h10, 1'b1, 3'd0);
    bulk(8'hFF, 8'hFF, 18);
    drain();
    // enable mask 0x0A: ch1 and ch3 alternate
    do_reset();
    push(32'h11, 1'b1, 3'd1);
    push(32'h13, 1'b1, 3'd3);
    push(32'h11, 1'b1, 3'd1);
    push(32'h13, 1'b1, 3'd3);
    bulk(8'hFF, 8'h0A, 8);
    drain();
    // ch2 with downstream stalls
    fork
      send(2, 4, 32'hC0, 8'b1000, 8'b1000);
      for (int i = 0; i < 16; i++) begin
        out_ready = (i % 3 == 0);
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1'b1;
    drain();
    // ch5 runaway packet: forced release at beat 4, then a 3-beat packet
    send(5, 7, 32'h50, 8'b0100_0000, 8'b0100_1000);
    @(negedge clk);
    check("len_err_set", {63'd0, len_err}, 64'd1);
    check("busy_after_forced", {63'd0, busy}, 64'd0);
    drain();
    // reset mid-packet on ch3 with output stalled
    send(3, 2, 32'hD0, 8'b00, 8'b00);
    void'(exp_q.pop_back());
    out_ready = 1'b0;
    in_valid[3] = 1'b1;
    in_data[3*DW +: DW] = 32'hD2;
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("reset_cycle_ready", {56'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = '0;
    @(negedge clk);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_len_err", {63'd0, len_err}, 64'd0);
    @(posedge clk);
    #1;
    // ptr cleared to 0: ch0 wins over ch7
    push(32'h10, 1'b1, 3'd0);
    push(32'h17, 1'b1, 3'd7);
    bulk(8'h81, 8'hFF, 4);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
